// File: rtl/decode_pipe_stage_pkg.sv
// Shared MIPS decode constants and the control-decode helper for decode_pipe_stage.
// DS_WB_BYPASS_EN (optional) is handled in the regfile and top, not here.
package decode_pipe_stage_pkg;

  localparam int IWIDTH       = 32;
  localparam int OPCODE_WIDTH = 6;
  localparam int FUNCT_WIDTH  = 6;
  localparam int IMM_WIDTH    = 16;
  localparam int JUMP_WIDTH   = 26;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = 6'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = 6'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = 6'd5;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'd8;
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 6'd12;
  localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = 6'd13;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'd35;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'd43;
  localparam logic [FUNCT_WIDTH-1:0]  FN_JR    = 6'd8;

  typedef struct packed {
    logic reg_wr;
    logic memwrite;
    logic memtoreg;
    logic alu_src;
    logic use_rt;
    logic is_rtype;
    logic is_beq;
    logic is_bne;
    logic is_jump;
    logic is_jal;
    logic is_jr;
    logic zero_ext;
  } ctrl_t;

  // Unknown opcodes fall through with every control bit clear.
  function automatic ctrl_t decode_ctrl(input logic [OPCODE_WIDTH-1:0] op,
                                        input logic [FUNCT_WIDTH-1:0] fn);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.is_rtype = 1'b1;
        c.use_rt   = 1'b1;
        if (fn == FN_JR) c.is_jr = 1'b1;
        else             c.reg_wr = 1'b1;
      end
      OP_J:   c.is_jump = 1'b1;
      OP_JAL: begin
        c.is_jump = 1'b1;
        c.is_jal  = 1'b1;
        c.reg_wr  = 1'b1;
      end
      OP_BEQ: begin
        c.is_beq = 1'b1;
        c.use_rt = 1'b1;
      end
      OP_BNE: begin
        c.is_bne = 1'b1;
        c.use_rt = 1'b1;
      end
      OP_ADDI: begin
        c.reg_wr  = 1'b1;
        c.alu_src = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        c.reg_wr   = 1'b1;
        c.alu_src  = 1'b1;
        c.zero_ext = 1'b1;
      end
      OP_LW: begin
        c.reg_wr   = 1'b1;
        c.alu_src  = 1'b1;
        c.memtoreg = 1'b1;
      end
      OP_SW: begin
        c.memwrite = 1'b1;
        c.alu_src  = 1'b1;
        c.use_rt   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_pipe_stage_regfile.sv
// Register file for decode_pipe_stage: NREGS x DWIDTH, 2 read / 1 write, r0 hardwired to zero.
// With DS_WB_BYPASS_EN defined, a same-cycle write is forwarded to the read ports.
module dp_regfile #(
  parameter int DWIDTH = 32,
  parameter int NREGS  = 32,
  parameter int AWIDTH = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] i_raddr_a,
  input  logic [AWIDTH-1:0] i_raddr_b,
  output logic [DWIDTH-1:0] o_rdata_a,
  output logic [DWIDTH-1:0] o_rdata_b,
  input  logic              i_we,
  input  logic [AWIDTH-1:0] i_waddr,
  input  logic [DWIDTH-1:0] i_wdata
);

  logic [DWIDTH-1:0] r_mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
    o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];
`ifdef DS_WB_BYPASS_EN
    if (i_we && (i_waddr != '0) && (i_raddr_a == i_waddr)) o_rdata_a = i_wdata;
    if (i_we && (i_waddr != '0) && (i_raddr_b == i_waddr)) o_rdata_b = i_wdata;
`endif
  end

endmodule

// File: rtl/decode_pipe_stage.sv
// MIPS decode stage: regfile read, early branch/jump resolution, hazard stall and ID/EX register.
// Optional macro DS_WB_BYPASS_EN: write-through regfile instead of stalling on a WB-stage match.
module decode_pipe_stage
  import decode_pipe_stage_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int PC_WIDTH = 32,
  parameter int NREGS    = 32,
  parameter int AWIDTH   = $clog2(NREGS)
) (
  input  logic                dp_clk,
  input  logic                dp_rst,
  input  logic                dp_i_valid,
  input  logic [IWIDTH-1:0]   dp_i_instr,
  input  logic [PC_WIDTH-1:0] dp_i_pc,
  input  logic                dp_i_wb_en,
  input  logic [AWIDTH-1:0]   dp_i_wb_addr,
  input  logic [DWIDTH-1:0]   dp_i_wb_data,
  input  logic                dp_i_mem_reg_wr,
  input  logic [AWIDTH-1:0]   dp_i_mem_addr_rd,
  output logic                dp_o_stall,
  output logic                dp_o_flush,
  output logic                dp_o_change_pc,
  output logic [PC_WIDTH-1:0] dp_o_pc_target,
  output logic                dp_o_valid,
  output logic [OPCODE_WIDTH-1:0] dp_o_opcode,
  output logic [FUNCT_WIDTH-1:0]  dp_o_funct,
  output logic [DWIDTH-1:0]   dp_o_data_rs,
  output logic [DWIDTH-1:0]   dp_o_data_rt,
  output logic [AWIDTH-1:0]   dp_o_addr_rs,
  output logic [AWIDTH-1:0]   dp_o_addr_rt,
  output logic [AWIDTH-1:0]   dp_o_addr_wr,
  output logic [DWIDTH-1:0]   dp_o_imm_ext,
  output logic                dp_o_alu_src,
  output logic                dp_o_reg_wr,
  output logic                dp_o_memwrite,
  output logic                dp_o_memtoreg,
  output logic [PC_WIDTH-1:0] dp_o_link_pc
);

  // Handshake: dp_i_valid qualifies IF/ID; while dp_o_stall=1 fetch holds PC and IF/ID so the
  // same instruction is re-presented. dp_o_valid qualifies ID/EX; execute never back-pressures.

  logic [OPCODE_WIDTH-1:0] w_opcode;
  logic [FUNCT_WIDTH-1:0]  w_funct;
  logic [AWIDTH-1:0]       w_rs, w_rt, w_rd, w_addr_wr;
  logic [IMM_WIDTH-1:0]    w_imm;
  logic [JUMP_WIDTH-1:0]   w_jidx;
  ctrl_t                   w_ctrl;
  logic [DWIDTH-1:0]       w_rs_data, w_rt_data, w_imm_ext;
  logic [PC_WIDTH-1:0]     w_pc_plus4, w_br_target, w_j_target, w_target;
  logic                    w_load_use, w_br_hazard, w_wb_hazard, w_hazard, w_accept, w_take;

  assign w_opcode = dp_i_instr[31:26];
  assign w_funct  = dp_i_instr[5:0];
  assign w_rs     = AWIDTH'(dp_i_instr[25:21]);
  assign w_rt     = AWIDTH'(dp_i_instr[20:16]);
  assign w_rd     = AWIDTH'(dp_i_instr[15:11]);
  assign w_imm    = dp_i_instr[15:0];
  assign w_jidx   = dp_i_instr[25:0];
  assign w_ctrl   = decode_ctrl(w_opcode, w_funct);

  dp_regfile #(.DWIDTH(DWIDTH), .NREGS(NREGS), .AWIDTH(AWIDTH)) u_regfile (
    .clk      (dp_clk),
    .rst_n    (dp_rst),
    .i_raddr_a(w_rs),
    .i_raddr_b(w_rt),
    .o_rdata_a(w_rs_data),
    .o_rdata_b(w_rt_data),
    .i_we     (dp_i_wb_en),
    .i_waddr  (dp_i_wb_addr),
    .i_wdata  (dp_i_wb_data)
  );

  assign w_addr_wr = w_ctrl.is_jal   ? AWIDTH'(5'd31) :
                     w_ctrl.is_rtype ? w_rd : w_rt;
  assign w_imm_ext = w_ctrl.zero_ext ? {{(DWIDTH-IMM_WIDTH){1'b0}}, w_imm}
                                     : {{(DWIDTH-IMM_WIDTH){w_imm[IMM_WIDTH-1]}}, w_imm};

  assign w_pc_plus4  = dp_i_pc + PC_WIDTH'(4);
  assign w_br_target = w_pc_plus4 + {{(PC_WIDTH-IMM_WIDTH-2){w_imm[IMM_WIDTH-1]}}, w_imm, 2'b00};
  assign w_j_target  = {w_pc_plus4[PC_WIDTH-1:28], w_jidx, 2'b00};

  // Register 0 never creates a dependency.
  function automatic logic src_match(input logic [AWIDTH-1:0] a, input logic [AWIDTH-1:0] rs,
                                     input logic [AWIDTH-1:0] rt, input logic use_rt);
    return (a != '0) && ((a == rs) || (use_rt && (a == rt)));
  endfunction

  assign w_load_use  = dp_o_valid && dp_o_memtoreg &&
                       src_match(dp_o_addr_wr, w_rs, w_rt, w_ctrl.use_rt);
  assign w_br_hazard = (w_ctrl.is_beq || w_ctrl.is_bne || w_ctrl.is_jr) &&
                       ((dp_o_valid && dp_o_reg_wr &&
                         src_match(dp_o_addr_wr, w_rs, w_rt, w_ctrl.use_rt)) ||
                        (dp_i_mem_reg_wr &&
                         src_match(dp_i_mem_addr_rd, w_rs, w_rt, w_ctrl.use_rt)));
`ifdef DS_WB_BYPASS_EN
  assign w_wb_hazard = 1'b0;
`else
  assign w_wb_hazard = dp_i_wb_en && src_match(dp_i_wb_addr, w_rs, w_rt, w_ctrl.use_rt);
`endif

  assign w_hazard   = w_load_use || w_br_hazard || w_wb_hazard;
  assign dp_o_stall = dp_i_valid && w_hazard;
  assign w_accept   = dp_i_valid && !w_hazard;

  always_comb begin
    w_take   = 1'b0;
    w_target = '0;
    if (w_accept) begin
      if (w_ctrl.is_beq && (w_rs_data == w_rt_data)) begin
        w_take   = 1'b1;
        w_target = w_br_target;
      end else if (w_ctrl.is_bne && (w_rs_data != w_rt_data)) begin
        w_take   = 1'b1;
        w_target = w_br_target;
      end else if (w_ctrl.is_jump) begin
        w_take   = 1'b1;
        w_target = w_j_target;
      end else if (w_ctrl.is_jr) begin
        w_take   = 1'b1;
        w_target = PC_WIDTH'(w_rs_data);
      end
    end
  end

  assign dp_o_change_pc = w_take;
  assign dp_o_flush     = w_take;
  assign dp_o_pc_target = w_target;

  // ID/EX register; a stalled or invalid slot becomes a bubble with all write controls clear.
  logic                    r_valid, r_alu_src, r_reg_wr, r_memwrite, r_memtoreg;
  logic [OPCODE_WIDTH-1:0] r_opcode;
  logic [FUNCT_WIDTH-1:0]  r_funct;
  logic [DWIDTH-1:0]       r_data_rs, r_data_rt, r_imm_ext;
  logic [AWIDTH-1:0]       r_addr_rs, r_addr_rt, r_addr_wr;
  logic [PC_WIDTH-1:0]     r_link_pc;

  always_ff @(posedge dp_clk or negedge dp_rst) begin
    if (!dp_rst) begin
      r_valid    <= 1'b0;
      r_alu_src  <= 1'b0;
      r_reg_wr   <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_opcode   <= '0;
      r_funct    <= '0;
      r_data_rs  <= '0;
      r_data_rt  <= '0;
      r_imm_ext  <= '0;
      r_addr_rs  <= '0;
      r_addr_rt  <= '0;
      r_addr_wr  <= '0;
      r_link_pc  <= '0;
    end else begin
      r_valid    <= w_accept;
      r_alu_src  <= w_accept && w_ctrl.alu_src;
      r_reg_wr   <= w_accept && w_ctrl.reg_wr;
      r_memwrite <= w_accept && w_ctrl.memwrite;
      r_memtoreg <= w_accept && w_ctrl.memtoreg;
      r_addr_wr  <= w_accept ? w_addr_wr : '0;
      r_opcode   <= w_opcode;
      r_funct    <= w_funct;
      r_data_rs  <= w_rs_data;
      r_data_rt  <= w_rt_data;
      r_imm_ext  <= w_imm_ext;
      r_addr_rs  <= w_rs;
      r_addr_rt  <= w_rt;
      r_link_pc  <= w_pc_plus4;
    end
  end

  assign dp_o_valid    = r_valid;
  assign dp_o_opcode   = r_opcode;
  assign dp_o_funct    = r_funct;
  assign dp_o_data_rs  = r_data_rs;
  assign dp_o_data_rt  = r_data_rt;
  assign dp_o_addr_rs  = r_addr_rs;
  assign dp_o_addr_rt  = r_addr_rt;
  assign dp_o_addr_wr  = r_addr_wr;
  assign dp_o_imm_ext  = r_imm_ext;
  assign dp_o_alu_src  = r_alu_src;
  assign dp_o_reg_wr   = r_reg_wr;
  assign dp_o_memwrite = r_memwrite;
  assign dp_o_memtoreg = r_memtoreg;
  assign dp_o_link_pc  = r_link_pc;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage: reference decode model feeds an expected-ID/EX queue.
// Honours DS_WB_BYPASS_EN when compiled with the same define as the RTL.
module tb_decode_pipe_stage;

`ifdef DS_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        dp_clk, dp_rst, dp_i_valid, dp_i_wb_en, dp_i_mem_reg_wr;
  logic [31:0] dp_i_instr, dp_i_pc, dp_i_wb_data;
  logic [4:0]  dp_i_wb_addr, dp_i_mem_addr_rd;
  logic        dp_o_stall, dp_o_flush, dp_o_change_pc, dp_o_valid;
  logic [31:0] dp_o_pc_target, dp_o_data_rs, dp_o_data_rt, dp_o_imm_ext, dp_o_link_pc;
  logic [5:0]  dp_o_opcode, dp_o_funct;
  logic [4:0]  dp_o_addr_rs, dp_o_addr_rt, dp_o_addr_wr;
  logic        dp_o_alu_src, dp_o_reg_wr, dp_o_memwrite, dp_o_memtoreg;

  decode_pipe_stage dut (
    .dp_clk(dp_clk), .dp_rst(dp_rst), .dp_i_valid(dp_i_valid), .dp_i_instr(dp_i_instr),
    .dp_i_pc(dp_i_pc), .dp_i_wb_en(dp_i_wb_en), .dp_i_wb_addr(dp_i_wb_addr),
    .dp_i_wb_data(dp_i_wb_data), .dp_i_mem_reg_wr(dp_i_mem_reg_wr),
    .dp_i_mem_addr_rd(dp_i_mem_addr_rd), .dp_o_stall(dp_o_stall), .dp_o_flush(dp_o_flush),
    .dp_o_change_pc(dp_o_change_pc), .dp_o_pc_target(dp_o_pc_target), .dp_o_valid(dp_o_valid),
    .dp_o_opcode(dp_o_opcode), .dp_o_funct(dp_o_funct), .dp_o_data_rs(dp_o_data_rs),
    .dp_o_data_rt(dp_o_data_rt), .dp_o_addr_rs(dp_o_addr_rs), .dp_o_addr_rt(dp_o_addr_rt),
    .dp_o_addr_wr(dp_o_addr_wr), .dp_o_imm_ext(dp_o_imm_ext), .dp_o_alu_src(dp_o_alu_src),
    .dp_o_reg_wr(dp_o_reg_wr), .dp_o_memwrite(dp_o_memwrite), .dp_o_memtoreg(dp_o_memtoreg),
    .dp_o_link_pc(dp_o_link_pc)
  );

  // ---------------- clock / reset ----------------
  initial dp_clk = 1'b0;
  always #5 dp_clk = ~dp_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        valid;
    logic [5:0]  opcode, funct;
    logic [31:0] rs_d, rt_d;
    logic [4:0]  a_rs, a_rt, a_wr;
    logic [31:0] imm;
    logic        alu_src, reg_wr, memwrite, memtoreg;
    logic [31:0] link;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_rf [32];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef DS_WB_BYPASS_EN
    if (dp_i_wb_en && (a == dp_i_wb_addr)) return dp_i_wb_data;
`endif
    return model_rf[a];
  endfunction

  // Reference MIPS decode of the expected ID/EX contents.
  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic acc);
    exp_t e;
    logic [5:0] op;
    e  = '0;
    op = ins[31:26];
    if (!acc) return e;
    e.valid  = 1'b1;
    e.opcode = op;
    e.funct  = ins[5:0];
    e.a_rs   = ins[25:21];
    e.a_rt   = ins[20:16];
    e.rs_d   = model_read(ins[25:21]);
    e.rt_d   = model_read(ins[20:16]);
    e.link   = pc + 32'd4;
    e.imm    = (op == 6'd12 || op == 6'd13) ? {16'd0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
    e.a_wr   = ins[20:16];
    case (op)
      6'd0:  begin e.reg_wr = (ins[5:0] != 6'd8); e.a_wr = ins[15:11]; end
      6'd3:  begin e.reg_wr = 1'b1; e.a_wr = 5'd31; end
      6'd8, 6'd12, 6'd13: begin e.reg_wr = 1'b1; e.alu_src = 1'b1; end
      6'd35: begin e.reg_wr = 1'b1; e.alu_src = 1'b1; e.memtoreg = 1'b1; end
      6'd43: begin e.memwrite = 1'b1; e.alu_src = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_idex(input exp_t e);
    chk("valid",    dp_o_valid,    e.valid);
    chk("reg_wr",   dp_o_reg_wr,   e.reg_wr);
    chk("memwrite", dp_o_memwrite, e.memwrite);
    chk("memtoreg", dp_o_memtoreg, e.memtoreg);
    if (e.valid) begin
      chk("opcode",  dp_o_opcode,  e.opcode);
      chk("funct",   dp_o_funct,   e.funct);
      chk("data_rs", dp_o_data_rs, e.rs_d);
      chk("data_rt", dp_o_data_rt, e.rt_d);
      chk("addr_rs", dp_o_addr_rs, e.a_rs);
      chk("addr_rt", dp_o_addr_rt, e.a_rt);
      chk("imm_ext", dp_o_imm_ext, e.imm);
      chk("link_pc", dp_o_link_pc, e.link);
      if (e.reg_wr) chk("addr_wr", dp_o_addr_wr, e.a_wr);
      if (e.reg_wr || e.memwrite) chk("alu_src", dp_o_alu_src, e.alu_src);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"},  dp_o_valid,  1'b0);
    chk({tag, "_opcode"}, dp_o_opcode, 6'd0);
    chk({tag, "_funct"},  dp_o_funct,  6'd0);
    chk({tag, "_rs"},     dp_o_data_rs, 32'd0);
    chk({tag, "_rt"},     dp_o_data_rt, 32'd0);
    chk({tag, "_ars"},    dp_o_addr_rs, 5'd0);
    chk({tag, "_art"},    dp_o_addr_rt, 5'd0);
    chk({tag, "_awr"},    dp_o_addr_wr, 5'd0);
    chk({tag, "_imm"},    dp_o_imm_ext, 32'd0);
    chk({tag, "_ctrl"},   {dp_o_alu_src, dp_o_reg_wr, dp_o_memwrite, dp_o_memtoreg}, 4'd0);
    chk({tag, "_link"},   dp_o_link_pc, 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  // Entered just after a falling edge; returns at the next falling edge.
  task automatic cycle(input logic vld, input logic [31:0] ins, input logic [31:0] pc,
                       input logic e_stall, input logic e_chg, input logic [31:0] e_tgt);
    exp_t e;
    dp_i_valid = vld;
    dp_i_instr = ins;
    dp_i_pc    = pc;
    exp_q.push_back(model_decode(ins, pc, vld && !e_stall));
    #1;
    chk("stall",     dp_o_stall,     e_stall);
    chk("flush",     dp_o_flush,     e_chg);
    chk("change_pc", dp_o_change_pc, e_chg);
    chk("pc_target", dp_o_pc_target, e_tgt);
    @(posedge dp_clk);
    if (dp_i_wb_en && dp_i_wb_addr != 5'd0) model_rf[dp_i_wb_addr] = dp_i_wb_data;
    #1;
    e = exp_q.pop_front();
    check_idex(e);
    dp_i_wb_en      = 1'b0;
    dp_i_mem_reg_wr = 1'b0;
    @(negedge dp_clk);
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    dp_i_wb_en   = 1'b1;
    dp_i_wb_addr = a;
    dp_i_wb_data = d;
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    dp_rst = 1'b0; dp_i_valid = 1'b0; dp_i_instr = '0; dp_i_pc = '0;
    dp_i_wb_en = 1'b0; dp_i_wb_addr = '0; dp_i_wb_data = '0;
    dp_i_mem_reg_wr = 1'b0; dp_i_mem_addr_rd = '0;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    repeat (2) @(posedge dp_clk);
    #1 check_zero("reset");
    @(negedge dp_clk);
    dp_rst = 1'b1;

    wb(5'd5, 32'h1234);
    cycle(1'b1, enc_r(5, 0, 6, 6'd32), 32'h10, 1'b0, 1'b0, 32'd0);

    // Reset asserted mid-stream with a valid instruction presented.
    dp_rst = 1'b0; dp_i_valid = 1'b1; dp_i_instr = enc_r(5, 0, 6, 6'd32); dp_i_pc = 32'h18;
    #1 check_zero("rst_async");
    @(posedge dp_clk);
    #1 check_zero("rst_hold");
    @(negedge dp_clk);
    dp_rst = 1'b1;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    cycle(1'b1, enc_r(5, 0, 6, 6'd32), 32'h14, 1'b0, 1'b0, 32'd0);

    wb(5'd1, 32'd7);
    wb(5'd2, 32'd7);
    wb(5'd4, 32'd3);

    // Load-use: one stall, one bubble, then the add.
    cycle(1'b1, enc_i(6'd35, 1, 2, 16'd0), 32'h20, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, enc_r(2, 4, 3, 6'd32), 32'h24, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, enc_r(2, 4, 3, 6'd32), 32'h24, 1'b0, 1'b0, 32'd0);

    // beq taken / not taken.
    cycle(1'b1, enc_i(6'd4, 1, 2, 16'd3), 32'h100, 1'b0, 1'b1, 32'h110);
    wb(5'd2, 32'd8);
    cycle(1'b1, enc_i(6'd4, 1, 2, 16'd3), 32'h100, 1'b0, 1'b0, 32'd0);

    // Branch-operand hazards: ID/EX writer, then MEM writer, then taken bne backwards.
    cycle(1'b1, enc_i(6'd8, 0, 1, 16'd9), 32'h1FC, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, enc_i(6'd5, 1, 2, 16'hFFFF), 32'h200, 1'b1, 1'b0, 32'd0);
    dp_i_mem_reg_wr = 1'b1; dp_i_mem_addr_rd = 5'd1;
    cycle(1'b1, enc_i(6'd5, 1, 2, 16'hFFFF), 32'h200, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, enc_i(6'd5, 1, 2, 16'hFFFF), 32'h200, 1'b0, 1'b1, 32'h200);

    // Jumps, and PC wrap on a branch at the top of the address space.
    cycle(1'b1, enc_j(6'd3, 26'h10), 32'h0040_0000, 1'b0, 1'b1, 32'h40);
    cycle(1'b1, enc_j(6'd2, 26'h3FF_FFFF), 32'hF000_0000, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, enc_i(6'd4, 0, 0, 16'd1), 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h4);

    // jr, including jr r0 against a MEM writer of r0.
    cycle(1'b1, enc_r(4, 0, 0, 6'd8), 32'h300, 1'b0, 1'b1, 32'd3);
    dp_i_mem_reg_wr = 1'b1; dp_i_mem_addr_rd = 5'd0;
    cycle(1'b1, enc_r(0, 0, 0, 6'd8), 32'h304, 1'b0, 1'b1, 32'd0);

    // Register 0 ignores writes.
    wb(5'd0, 32'h55);
    cycle(1'b1, enc_r(0, 0, 10, 6'd32), 32'h308, 1'b0, 1'b0, 32'd0);

    // Same-cycle writeback of a source register.
    dp_i_wb_en = 1'b1; dp_i_wb_addr = 5'd9; dp_i_wb_data = 32'hDEAD;
    cycle(1'b1, enc_r(9, 0, 1, 6'd32), 32'h400, !BYP, 1'b0, 32'd0);
    cycle(1'b1, enc_r(9, 0, 1, 6'd32), 32'h400, 1'b0, 1'b0, 32'd0);

    // Immediate extension, store, unknown opcode.
    cycle(1'b1, enc_i(6'd13, 1, 3, 16'h8000), 32'h500, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, enc_i(6'd8, 1, 3, 16'h8000), 32'h504, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, enc_i(6'd43, 1, 2, 16'd4), 32'h508, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, enc_i(6'd63, 1, 2, 16'd0), 32'h50C, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_pipe_stage.md
Name: decode_pipe_stage

Overview:
- Parametrised successor to the single-cycle decode stage.
- Decodes a MIPS instruction, reads a parametrised register file, resolves beq/bne/j/jal/jr in decode, detects load-use and branch-operand hazards, and registers the results into an ID/EX pipeline register with valid.
- Sits between the IF/ID register and the execute stage. It drives stall and flush back to fetch.

Parameters:
- DWIDTH, 32, register/data width.
- PC_WIDTH, 32, program counter width.
- NREGS, 32, register count. AWIDTH = clog2(NREGS). Register 0 reads zero and ignores writes.

Ports:
- dp_clk  in  1  clock, rising edge.
- dp_rst  in  1  asynchronous reset, active-low.
- dp_i_valid  in  1  IF/ID holds a valid instruction.
- dp_i_instr  in  32  instruction.
- dp_i_pc  in  PC_WIDTH  PC of the instruction.
- dp_i_wb_en  in  1  writeback write enable.
- dp_i_wb_addr  in  AWIDTH  writeback register.
- dp_i_wb_data  in  DWIDTH  writeback data.
- dp_i_mem_reg_wr  in  1  MEM-stage instruction writes a register.
- dp_i_mem_addr_rd  in  AWIDTH  MEM-stage destination register.
- dp_o_stall  out  1  hold PC and IF/ID this cycle.
- dp_o_flush  out  1  kill the IF/ID contents at the next edge.
- dp_o_change_pc  out  1  redirect fetch.
- dp_o_pc_target  out  PC_WIDTH  redirect target.
- dp_o_valid  out  1  ID/EX holds a valid instruction.
- dp_o_opcode  out  6  registered opcode.
- dp_o_funct  out  6  registered funct.
- dp_o_data_rs  out  DWIDTH  registered rs operand.
- dp_o_data_rt  out  DWIDTH  registered rt operand.
- dp_o_addr_rs  out  AWIDTH  registered rs address.
- dp_o_addr_rt  out  AWIDTH  registered rt address (for forwarding).
- dp_o_addr_wr  out  AWIDTH  destination: rd (R-type), rt (I-type), 31 (jal).
- dp_o_imm_ext  out  DWIDTH  sign-extended imm; zero-extended for andi/ori.
- dp_o_alu_src  out  1  registered control.
- dp_o_reg_wr  out  1  registered control.
- dp_o_memwrite  out  1  registered control.
- dp_o_memtoreg  out  1  registered control.
- dp_o_link_pc  out  PC_WIDTH  dp_i_pc+4, used as the jal writeback value.

Behaviour:
- Reset (dp_rst=0, async): all ID/EX outputs 0, dp_o_valid=0, all registers 0. Combinational outputs follow their inputs.
- Latency: an instruction accepted at edge n appears on the ID/EX outputs after edge n. One instruction per cycle when not stalled.
- Regfile write: at the edge when dp_i_wb_en=1 and dp_i_wb_addr!=0.
- Hazard, load-use: ID/EX valid, memtoreg=1, dp_o_addr_wr!=0 and equal to a source register used by the decoding instruction (rs always; rt for R-type, beq, bne, sw).
- Hazard, branch operand: decoding instruction is beq, bne or jr, and a source matches either:
  - a valid ID/EX writer (dp_o_reg_wr=1), or
  - a MEM writer (dp_i_mem_reg_wr=1 and dp_i_mem_addr_rd).
  Address 0 never matches.
- On hazard with dp_i_valid=1:
  - dp_o_stall=1.
  - Bubble into ID/EX: dp_o_valid=0 and all write/control bits 0; data outputs don't care.
  - No redirect.
- Redirect: evaluated only when dp_i_valid=1 and not stalled.
  - beq taken when rs==rt; bne taken when rs!=rt. Target = pc+4 + (sext(imm)<<2).
  - j/jal: target = {(pc+4)[PC_WIDTH-1:28], instr[25:0], 2'b00}.
  - jr: target = rs data.
  - On redirect: dp_o_change_pc=1 and dp_o_flush=1, both combinational. The branch itself still enters ID/EX.
  - When not redirecting, dp_o_pc_target=0.
- dp_i_valid=0: bubble enters ID/EX; stall, flush and change_pc are all 0.
- Unknown opcode: passes with reg_wr=0 and memwrite=0; dp_o_valid follows dp_i_valid.
- Width arithmetic: PC adds wrap modulo 2^PC_WIDTH.

Optional Feature:
- Macro DS_WB_BYPASS_EN.
- Defined: a read whose address equals dp_i_wb_addr, while dp_i_wb_en=1 and the address is !=0, returns dp_i_wb_data in the same cycle (write-through).
- Undefined: reads return the stored value. The hazard unit additionally stalls when a source used by the decoding instruction matches the WB writer.

Decomposition:
- Shared package: opcode/funct constants (RTYPE 0, J 2, JAL 3, BEQ 4, BNE 5, ADDI 8, ANDI 12, ORI 13, LW 35, SW 43, JR funct 8), and widths IWIDTH, OPCODE_WIDTH, FUNCT_WIDTH, IMM_WIDTH, JUMP_WIDTH.
- Sub-module dp_regfile: NREGS x DWIDTH, two read ports and one write port, with the optional bypass inside. Hazard, redirect and ID/EX logic stay in the top level.

Test Plan:
- Reset mid-stream: hold dp_rst=0 while valid instructions are presented -> dp_o_valid=0, every ID/EX output 0, and r5 reads 0 after release.
- Load-use: lw r2,0(r1), then add r3,r2,r4 -> dp_o_stall=1 for 1 cycle, one bubble (dp_o_valid=0), then add with dp_o_addr_wr=3.
- beq taken: pc=0x100, r1=r2=7, imm=3 -> dp_o_change_pc=1, dp_o_flush=1, target 0x110. With r2=8 -> change_pc=0.
- jal: pc=0x0040_0000, target field 0x10 -> target 0x0000_0040, dp_o_addr_wr=31, dp_o_link_pc=0x0040_0004.
- Same-cycle writeback: write r9=0xDEAD while decoding add r1,r9,r0 -> with DS_WB_BYPASS_EN, dp_o_data_rs=0xDEAD next cycle and no stall. Without the macro, one stall cycle, then 0xDEAD.
- Register 0: wb r0=0x55, then read r0 -> 0. jr r0 with MEM writer addr 0 -> no stall, target 0.
